mod_counter_bank: RTL and testbench
===================================

MOD_COUNTER_BANK -- requirements
Module: mod_counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter width per channel in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of independent counter channels.
REQ-003 SHALL have parameter INC_STEP, default 1, meaning increment amount (1..2^WIDTH-1).
REQ-004 SHALL have parameter DEC_STEP, default 1, meaning decrement amount (1..2^WIDTH-1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port inc, input, NUM_CH bits: per-channel increment request.
REQ-008 SHALL have port dec, input, NUM_CH bits: per-channel decrement request.
REQ-009 SHALL have port clear, input, NUM_CH bits: per-channel synchronous clear to 0.
REQ-010 SHALL have port load, input, NUM_CH bits: per-channel load strobe.
REQ-011 SHALL have port load_val, input, NUM_CH*WIDTH bits: load value, channel i in bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port limit, input, NUM_CH*WIDTH bits: per-channel maximum count (modulus-1), same packing.
REQ-013 SHALL have port mode_sat, input, NUM_CH bits: 1 = saturate, 0 = wrap.
REQ-014 SHALL have port count, output, NUM_CH*WIDTH bits: registered count, same packing.
REQ-015 SHALL have port at_max, output, NUM_CH bits: count == limit (combinational from registered count and current limit).
REQ-016 SHALL have port at_zero, output, NUM_CH bits: count == 0 (combinational from registered count).
REQ-017 SHALL have port tc_pulse, output, NUM_CH bits: registered one-cycle terminal-count event, coincident with the new count.

Function
REQ-018 Channels SHALL be fully independent; per-channel priority: clear > load > range correction > inc/dec.
REQ-019 clear SHALL set count to 0 next edge, tc_pulse 0.
REQ-020 load SHALL set count to load_val; if load_val > limit, count SHALL become limit.
REQ-021 If count > limit (limit lowered) with no clear/load, next count SHALL be 0 (wrap) or limit (sat), inc/dec ignored, tc_pulse 1.
REQ-022 Net step: inc only = +INC_STEP; dec only = -DEC_STEP; both = +(INC_STEP-DEC_STEP) if positive, -(DEC_STEP-INC_STEP) if negative, hold if equal; neither = hold.
REQ-023 Arithmetic SHALL use WIDTH+1 bits internally; no silent 2^WIDTH aliasing.
REQ-024 Up step with count+s <= limit: count+s, tc_pulse 0.
REQ-025 Up step with count+s > limit: wrap mode count+s-(limit+1); sat mode limit; tc_pulse 1 either way.
REQ-026 Down step with count >= s: count-s, tc_pulse 0.
REQ-027 Down step with count < s: wrap mode count+(limit+1)-s; sat mode 0; tc_pulse 1 either way.
REQ-028 Wrap mode with s > limit+1: up SHALL give limit, down SHALL give 0, tc_pulse 1.
REQ-029 limit = 0 SHALL pin count at 0 under any step; tc_pulse 1 on every stepping cycle.
REQ-030 Latency: inputs sampled at edge N, count/tc_pulse valid after edge N; at_max/at_zero follow count same cycle.

Reset
REQ-031 reset SHALL, at the next rising edge, set all count to 0, tc_pulse to 0 and (if compiled) err_sticky to 0, overriding all other inputs.
REQ-032 Reset mid-operation SHALL discard the in-flight update; no tc_pulse in the cycle after reset.

Configuration
REQ-033 Macro MOD_COUNTER_BANK_ERR_EN defined: output err_sticky, NUM_CH bits, per channel set by clipped load (REQ-020), range correction (REQ-021), sat-mode clip, or REQ-028; cleared only by reset or that channel's clear.
REQ-034 Macro MOD_COUNTER_BANK_ERR_EN undefined: err_sticky port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Wrap: limit=9, mode_sat=0, inc held 12 cycles from 0 -> count 1..9,0,1,2; tc_pulse only with count=0.
REQ-036 Sat: limit=5, mode_sat=1, count=1, dec 3 cycles -> 0,0,0; tc_pulse on cycles 2,3; err_sticky 1 (ERR_EN).
REQ-037 Simultaneous: INC_STEP=3, DEC_STEP=1, count=8, limit=9, wrap, inc&dec -> 0, tc_pulse 1; again -> 2, tc_pulse 0.
REQ-038 Priority: clear+load+inc same cycle -> 0; then load_val=20, limit=9 -> 9, err_sticky 1.
REQ-039 Limit drop: count=7, limit changed to 3, wrap mode, inc asserted -> 0, tc_pulse 1; sat mode -> 3.
REQ-040 Reset: count=7, reset 1 cycle with inc asserted -> count 0, tc_pulse 0, at_zero 1, err_sticky 0.

Source files
------------

// File: rtl/mod_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_bank_if
// Description : Bundles the per-channel control strobes, packed load/limit
//               values and status outputs of the counter bank. err_sticky
//               exists only when MOD_COUNTER_BANK_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_counter_bank_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]       inc;
    logic [NUM_CH-1:0]       dec;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] load_val;
    logic [NUM_CH*WIDTH-1:0] limit;
    logic [NUM_CH-1:0]       mode_sat;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       at_max;
    logic [NUM_CH-1:0]       at_zero;
    logic [NUM_CH-1:0]       tc_pulse;
`ifdef MOD_COUNTER_BANK_ERR_EN
    logic [NUM_CH-1:0]       err_sticky;
`endif

    // Requester side: drives controls, observes counts and flags
    modport master (
        output inc, dec, clear, load, load_val, limit, mode_sat,
        input  count, at_max, at_zero, tc_pulse
`ifdef MOD_COUNTER_BANK_ERR_EN
        , input err_sticky
`endif
    );

    // Counter bank side
    modport slave (
        input  inc, dec, clear, load, load_val, limit, mode_sat,
        output count, at_max, at_zero, tc_pulse
`ifdef MOD_COUNTER_BANK_ERR_EN
        , output err_sticky
`endif
    );
endinterface
`default_nettype wire

// File: rtl/mod_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_bank
// Description : NUM_CH independent up/down counters with per-channel modulus
//               (limit), wrap or saturate mode, clear, load and a registered
//               terminal-count pulse. Optional per-channel sticky error flag
//               enabled by defining MOD_COUNTER_BANK_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int INC_STEP = 1,
    parameter int DEC_STEP = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mod_counter_bank_if.slave bus
);

    // Step magnitudes carried at WIDTH+1 bits so sums never alias mod 2^WIDTH
    localparam logic [WIDTH:0] c_INC     = (WIDTH+1)'(INC_STEP);
    localparam logic [WIDTH:0] c_DEC     = (WIDTH+1)'(DEC_STEP);
    localparam bit             c_BOTH_UP = (INC_STEP > DEC_STEP);
    localparam bit             c_BOTH_DN = (INC_STEP < DEC_STEP);
    localparam logic [WIDTH:0] c_BOTH_S  = c_BOTH_UP ? (c_INC - c_DEC) : (c_DEC - c_INC);

    logic [NUM_CH*WIDTH-1:0] r_count;
    logic [NUM_CH-1:0]       r_tc;
    logic [NUM_CH*WIDTH-1:0] w_count_nxt;
    logic [NUM_CH-1:0]       w_tc_nxt;
    logic [NUM_CH-1:0]       w_err_set;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [WIDTH-1:0] w_cnt;
        logic [WIDTH-1:0] w_lim;
        logic [WIDTH-1:0] w_ld;
        logic [WIDTH-1:0] w_nxt;
        logic [WIDTH:0]   w_lim1;
        logic [WIDTH:0]   w_s;
        logic [WIDTH:0]   w_sum;
        logic             w_up;
        logic             w_dn;
        logic             w_tc;
        logic             w_err;

        assign w_cnt  = r_count[ch*WIDTH +: WIDTH];
        assign w_lim  = bus.limit[ch*WIDTH +: WIDTH];
        assign w_ld   = bus.load_val[ch*WIDTH +: WIDTH];
        assign w_lim1 = {1'b0, w_lim} + 1'b1;
        assign w_sum  = {1'b0, w_cnt} + w_s;

        // Resolve inc/dec requests into one net step direction and magnitude
        always_comb begin
            w_up = 1'b0;
            w_dn = 1'b0;
            w_s  = '0;
            case ({bus.inc[ch], bus.dec[ch]})
                2'b10: begin
                    w_up = 1'b1;
                    w_s  = c_INC;
                end
                2'b01: begin
                    w_dn = 1'b1;
                    w_s  = c_DEC;
                end
                2'b11: begin
                    w_up = c_BOTH_UP;
                    w_dn = c_BOTH_DN;
                    w_s  = c_BOTH_S;
                end
                default: ;
            endcase
        end

        // Next count: clear > load > out-of-range correction > net step
        always_comb begin
            w_nxt = w_cnt;
            w_tc  = 1'b0;
            w_err = 1'b0;
            if (bus.clear[ch]) begin
                w_nxt = '0;
            end else if (bus.load[ch]) begin
                if (w_ld > w_lim) begin
                    w_nxt = w_lim;
                    w_err = 1'b1;
                end else begin
                    w_nxt = w_ld;
                end
            end else if (w_cnt > w_lim) begin
                // Limit was lowered beneath the current count
                w_nxt = bus.mode_sat[ch] ? w_lim : '0;
                w_tc  = 1'b1;
                w_err = 1'b1;
            end else if (w_up) begin
                if (w_sum <= {1'b0, w_lim}) begin
                    w_nxt = w_sum[WIDTH-1:0];
                end else begin
                    w_tc = 1'b1;
                    if (bus.mode_sat[ch]) begin
                        w_nxt = w_lim;
                        w_err = 1'b1;
                    end else if (w_s > w_lim1) begin
                        // Step exceeds the modulus; a wrap is undefined, so clip
                        w_nxt = w_lim;
                        w_err = 1'b1;
                    end else begin
                        w_nxt = WIDTH'(w_sum - w_lim1);
                    end
                end
            end else if (w_dn) begin
                if ({1'b0, w_cnt} >= w_s) begin
                    w_nxt = WIDTH'({1'b0, w_cnt} - w_s);
                end else begin
                    w_tc = 1'b1;
                    if (bus.mode_sat[ch]) begin
                        w_nxt = '0;
                        w_err = 1'b1;
                    end else if (w_s > w_lim1) begin
                        w_nxt = '0;
                        w_err = 1'b1;
                    end else begin
                        w_nxt = WIDTH'({1'b0, w_cnt} + w_lim1 - w_s);
                    end
                end
            end
        end

        assign w_count_nxt[ch*WIDTH +: WIDTH] = w_nxt;
        assign w_tc_nxt[ch]                   = w_tc;
        assign w_err_set[ch]                  = w_err;

        // Status flags follow the registered count and the live limit
        assign bus.at_max[ch]  = (w_cnt == w_lim);
        assign bus.at_zero[ch] = (w_cnt == '0);
    end

    // Count and terminal-count registers; reset overrides every request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign bus.count    = r_count;
    assign bus.tc_pulse = r_tc;

`ifdef MOD_COUNTER_BANK_ERR_EN
    logic [NUM_CH-1:0] r_err;

    // Sticky error: set by any clipping event, cleared by reset or channel clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err | w_err_set) & ~bus.clear;
        end
    end

    assign bus.err_sticky = r_err;
`else
    logic [NUM_CH-1:0] w_unused_err;
    assign w_unused_err = w_err_set;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter_bank
// Description : Directed self-checking bench for mod_counter_bank. A second
//               instance with INC_STEP=3 covers unequal simultaneous steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter_bank;
    localparam int W = 8;
    localparam int N = 4;

    logic clk;
    logic reset;
    integer checks;
    integer errors;

    mod_counter_bank_if #(.WIDTH(W), .NUM_CH(N)) bus ();
    mod_counter_bank_if #(.WIDTH(W), .NUM_CH(N)) bus3 ();

    mod_counter_bank #(.WIDTH(W), .NUM_CH(N), .INC_STEP(1), .DEC_STEP(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mod_counter_bank #(.WIDTH(W), .NUM_CH(N), .INC_STEP(3), .DEC_STEP(1)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.inc = '0;  bus.dec = '0;  bus.clear = '0;  bus.load = '0;
        bus.load_val = '0;  bus.limit = {N{8'd255}};  bus.mode_sat = '0;
        bus3.inc = '0; bus3.dec = '0; bus3.clear = '0; bus3.load = '0;
        bus3.load_val = '0; bus3.limit = {N{8'd255}}; bus3.mode_sat = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.count !== 32'h0) begin
            errors++;
            $display("FAIL reset_count got %h exp %h", bus.count, 32'h0);
        end
        checks++;
        if (bus.tc_pulse !== 4'h0) begin
            errors++;
            $display("FAIL reset_tc got %h exp %h", bus.tc_pulse, 4'h0);
        end
        checks++;
        if (bus.at_zero !== 4'hF) begin
            errors++;
            $display("FAIL reset_at_zero got %h exp %h", bus.at_zero, 4'hF);
        end
        checks++;
        if (bus.at_max !== 4'h0) begin
            errors++;
            $display("FAIL reset_at_max got %h exp %h", bus.at_max, 4'h0);
        end
        checks++;
        if (bus3.count !== 32'h0) begin
            errors++;
            $display("FAIL reset_count3 got %h exp %h", bus3.count, 32'h0);
        end
    endtask

    // Channel 0: limit 9, wrap, inc held 12 cycles
    task automatic test_wrap();
        logic [7:0] exp_c;
        bus.limit[0 +: 8] = 8'd9;
        bus.mode_sat[0]   = 1'b0;
        bus.inc[0]        = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_c = 8'(i % 10);
            checks++;
            if (bus.count[0 +: 8] !== exp_c) begin
                errors++;
                $display("FAIL wrap_count cyc %0d got %0d exp %0d", i, bus.count[0 +: 8], exp_c);
            end
            checks++;
            if (bus.tc_pulse[0] !== (exp_c == 8'd0)) begin
                errors++;
                $display("FAIL wrap_tc cyc %0d got %b exp %b", i, bus.tc_pulse[0], (exp_c == 8'd0));
            end
            checks++;
            if (bus.at_max[0] !== (exp_c == 8'd9)) begin
                errors++;
                $display("FAIL wrap_at_max cyc %0d got %b exp %b", i, bus.at_max[0], (exp_c == 8'd9));
            end
        end
        bus.inc[0] = 1'b0;
        checks++;
        if (bus.count[W*N-1:8] !== 24'h0) begin
            errors++;
            $display("FAIL wrap_independent got %h exp %h", bus.count[W*N-1:8], 24'h0);
        end
    endtask

    // Channel 1: limit 5, saturate, load 1 then dec 3 cycles
    task automatic test_sat();
        logic [2:0] exp_tc;
        exp_tc = 3'b110;
        bus.limit[8 +: 8]    = 8'd5;
        bus.mode_sat[1]      = 1'b1;
        bus.load_val[8 +: 8] = 8'd1;
        bus.load[1]          = 1'b1;
        step();
        bus.load[1] = 1'b0;
        checks++;
        if (bus.count[8 +: 8] !== 8'd1) begin
            errors++;
            $display("FAIL sat_load got %0d exp %0d", bus.count[8 +: 8], 1);
        end
        bus.dec[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.count[8 +: 8] !== 8'd0) begin
                errors++;
                $display("FAIL sat_count cyc %0d got %0d exp %0d", i + 1, bus.count[8 +: 8], 0);
            end
            checks++;
            if (bus.tc_pulse[1] !== exp_tc[i]) begin
                errors++;
                $display("FAIL sat_tc cyc %0d got %b exp %b", i + 1, bus.tc_pulse[1], exp_tc[i]);
            end
        end
        bus.dec[1] = 1'b0;
`ifdef MOD_COUNTER_BANK_ERR_EN
        checks++;
        if (bus.err_sticky[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_err got %b exp %b", bus.err_sticky[1], 1'b1);
        end
`endif
    endtask

    // INC_STEP=3/DEC_STEP=1 instance: net +2 with wrap, then oversize step
    task automatic test_simultaneous();
        bus3.limit[0 +: 8]    = 8'd9;
        bus3.load_val[0 +: 8] = 8'd8;
        bus3.load[0]          = 1'b1;
        step();
        bus3.load[0] = 1'b0;
        bus3.inc[0]  = 1'b1;
        bus3.dec[0]  = 1'b1;
        step();
        checks++;
        if (bus3.count[0 +: 8] !== 8'd0 || bus3.tc_pulse[0] !== 1'b1) begin
            errors++;
            $display("FAIL simul_first got %0d/%b exp 0/1", bus3.count[0 +: 8], bus3.tc_pulse[0]);
        end
        step();
        checks++;
        if (bus3.count[0 +: 8] !== 8'd2 || bus3.tc_pulse[0] !== 1'b0) begin
            errors++;
            $display("FAIL simul_second got %0d/%b exp 2/0", bus3.count[0 +: 8], bus3.tc_pulse[0]);
        end
        bus3.inc[0] = 1'b0;
        bus3.dec[0] = 1'b0;
        // Channel 1: step 3 exceeds modulus 2 -> clip to limit
        bus3.limit[8 +: 8] = 8'd1;
        bus3.inc[1]        = 1'b1;
        step();
        checks++;
        if (bus3.count[8 +: 8] !== 8'd1 || bus3.tc_pulse[1] !== 1'b1) begin
            errors++;
            $display("FAIL big_step_up got %0d/%b exp 1/1", bus3.count[8 +: 8], bus3.tc_pulse[1]);
        end
        bus3.inc[1] = 1'b0;
        bus3.dec[1] = 1'b1;
        step();
        bus3.dec[1] = 1'b0;
        checks++;
        if (bus3.count[8 +: 8] !== 8'd0 || bus3.tc_pulse[1] !== 1'b0) begin
            errors++;
            $display("FAIL big_step_dec got %0d/%b exp 0/0", bus3.count[8 +: 8], bus3.tc_pulse[1]);
        end
    endtask

    // Channel 2: clear beats load beats inc; clipped load
    task automatic test_priority();
        bus.load_val[16 +: 8] = 8'd5;
        bus.load[2]           = 1'b1;
        step();
        checks++;
        if (bus.count[16 +: 8] !== 8'd5) begin
            errors++;
            $display("FAIL prio_load got %0d exp %0d", bus.count[16 +: 8], 5);
        end
        bus.load_val[16 +: 8] = 8'd7;
        bus.clear[2]          = 1'b1;
        bus.inc[2]            = 1'b1;
        step();
        bus.clear[2] = 1'b0;
        bus.inc[2]   = 1'b0;
        checks++;
        if (bus.count[16 +: 8] !== 8'd0) begin
            errors++;
            $display("FAIL prio_clear got %0d exp %0d", bus.count[16 +: 8], 0);
        end
        bus.limit[16 +: 8]    = 8'd9;
        bus.load_val[16 +: 8] = 8'd20;
        step();
        bus.load[2] = 1'b0;
        checks++;
        if (bus.count[16 +: 8] !== 8'd9 || bus.at_max[2] !== 1'b1) begin
            errors++;
            $display("FAIL prio_clip got %0d/%b exp 9/1", bus.count[16 +: 8], bus.at_max[2]);
        end
`ifdef MOD_COUNTER_BANK_ERR_EN
        checks++;
        if (bus.err_sticky[2] !== 1'b1) begin
            errors++;
            $display("FAIL prio_err got %b exp %b", bus.err_sticky[2], 1'b1);
        end
`endif
    endtask

    // Channel 3: limit lowered under the count
    task automatic test_limit_drop();
        bus.load_val[24 +: 8] = 8'd7;
        bus.load[3]           = 1'b1;
        step();
        bus.load[3]        = 1'b0;
        bus.limit[24 +: 8] = 8'd3;
        bus.inc[3]         = 1'b1;
        step();
        checks++;
        if (bus.count[24 +: 8] !== 8'd0 || bus.tc_pulse[3] !== 1'b1) begin
            errors++;
            $display("FAIL drop_wrap got %0d/%b exp 0/1", bus.count[24 +: 8], bus.tc_pulse[3]);
        end
        bus.inc[3]         = 1'b0;
        bus.limit[24 +: 8] = 8'd255;
        bus.load[3]        = 1'b1;
        step();
        bus.load[3]        = 1'b0;
        bus.limit[24 +: 8] = 8'd3;
        bus.mode_sat[3]    = 1'b1;
        bus.inc[3]         = 1'b1;
        step();
        bus.inc[3] = 1'b0;
        checks++;
        if (bus.count[24 +: 8] !== 8'd3 || bus.tc_pulse[3] !== 1'b1) begin
            errors++;
            $display("FAIL drop_sat got %0d/%b exp 3/1", bus.count[24 +: 8], bus.tc_pulse[3]);
        end
    endtask

    // Channel 0: down wrap from zero, then limit 0 pinning
    task automatic test_down_and_zero_limit();
        bus.clear[0] = 1'b1;
        step();
        bus.clear[0] = 1'b0;
        bus.dec[0]   = 1'b1;
        step();
        bus.dec[0] = 1'b0;
        checks++;
        if (bus.count[0 +: 8] !== 8'd9 || bus.tc_pulse[0] !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap got %0d/%b exp 9/1", bus.count[0 +: 8], bus.tc_pulse[0]);
        end
        bus.clear[0] = 1'b1;
        step();
        bus.clear[0]      = 1'b0;
        bus.limit[0 +: 8] = 8'd0;
        bus.inc[0]        = 1'b1;
        step();
        bus.inc[0] = 1'b0;
        checks++;
        if (bus.count[0 +: 8] !== 8'd0 || bus.tc_pulse[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_lim_inc got %0d/%b exp 0/1", bus.count[0 +: 8], bus.tc_pulse[0]);
        end
        bus.dec[0] = 1'b1;
        step();
        bus.dec[0] = 1'b0;
        checks++;
        if (bus.count[0 +: 8] !== 8'd0 || bus.tc_pulse[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_lim_dec got %0d/%b exp 0/1", bus.count[0 +: 8], bus.tc_pulse[0]);
        end
        bus.limit[0 +: 8] = 8'd9;
    endtask

    // Reset with a pending increment discards it
    task automatic test_reset_mid();
        bus.load_val[0 +: 8] = 8'd7;
        bus.load[0]          = 1'b1;
        step();
        bus.load[0] = 1'b0;
        checks++;
        if (bus.count[0 +: 8] !== 8'd7) begin
            errors++;
            $display("FAIL rmid_load got %0d exp %0d", bus.count[0 +: 8], 7);
        end
        bus.inc[0] = 1'b1;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        bus.inc[0] = 1'b0;
        checks++;
        if (bus.count !== 32'h0 || bus.tc_pulse !== 4'h0 || bus.at_zero[0] !== 1'b1) begin
            errors++;
            $display("FAIL rmid_state got %h/%h/%b exp 0/0/1", bus.count, bus.tc_pulse, bus.at_zero[0]);
        end
`ifdef MOD_COUNTER_BANK_ERR_EN
        checks++;
        if (bus.err_sticky !== 4'h0) begin
            errors++;
            $display("FAIL rmid_err got %h exp %h", bus.err_sticky, 4'h0);
        end
`endif
        step();
        checks++;
        if (bus.tc_pulse !== 4'h0 || bus.count !== 32'h0) begin
            errors++;
            $display("FAIL rmid_after got %h/%h exp 0/0", bus.tc_pulse, bus.count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        test_reset();
        test_wrap();
        test_sat();
        test_simultaneous();
        test_priority();
        test_limit_drop();
        test_down_and_zero_limit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
